// File: rtl/trigger_sequencer.sv
// Lab trigger-bench stimulus controller: a debounced button steps through four
// trigger-test modes, each playing one framed, cycle-exact ch3/ch4 pattern.
//
// state | meaning
// IDLE  | waiting for a debounced press, outputs idle
// ARM   | frame open (ch8 low), quiet gap before the burst
// BURST | playing the current mode's pattern on ch3/ch4
// POST  | quiet gap after the burst, frame still open
// DONE  | frame closed, mode advances on exit
module trigger_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 4,
  parameter int GAP_CYCLES      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sw2,
  output logic ch3,
  output logic ch4,
  output logic ch6,
  output logic ch7,
  output logic ch8,
  output logic busy,
  output logic rLed,
  output logic gLed,
  output logic bLed
);

  localparam int MAX_PG  = (5 * PULSE_CYCLES > GAP_CYCLES) ? 5 * PULSE_CYCLES : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_PG > DEBOUNCE_CYCLES) ? MAX_PG : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] P1     = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] P2     = CW'(2 * PULSE_CYCLES);
  localparam logic [CW-1:0] P4     = CW'(4 * PULSE_CYCLES);
  localparam logic [CW-1:0] P5     = CW'(5 * PULSE_CYCLES);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] DB_LD  = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    BURST = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  logic          sw2_s1, sw2_s2, sw2_db, sw2_db_q, press;
  logic [CW-1:0] db_cnt, timer, burst_len;
  logic [1:0]    mode, mode_inc;

  assign burst_len = (mode == 2'd2) ? P5 : P2;
  assign mode_inc  = mode + 2'd1;

  // {ch3, ch4} for burst cycle k of mode m
  function automatic logic [1:0] pattern(input logic [1:0] m, input logic [CW-1:0] k);
    case (m)
      2'd0:    pattern = {k < P1, k >= P1};
      2'd1:    pattern = {1'b1, k >= P1};
      2'd2:    pattern = {(k < P1) || ((k >= P2) && (k < P4)), 1'b0};
      default: pattern = {k[0], 1'b1};
    endcase
  endfunction

  // {r, g, b}, active-low
  function automatic logic [2:0] led_code(input logic [1:0] m);
    case (m)
      2'd0:    led_code = 3'b011;
      2'd1:    led_code = 3'b101;
      2'd2:    led_code = 3'b110;
      default: led_code = 3'b000;
    endcase
  endfunction

  // Debounce counts consecutive samples that disagree with the settled level;
  // press is registered once more so no output has a short path from sw2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw2_s1   <= 1'b0;
      sw2_s2   <= 1'b0;
      sw2_db   <= 1'b0;
      sw2_db_q <= 1'b0;
      press    <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sw2_s1   <= sw2;
      sw2_s2   <= sw2_s1;
      sw2_db_q <= sw2_db;
      press    <= sw2_db & ~sw2_db_q;
      if (sw2_s2 == sw2_db) begin
        db_cnt <= DB_LD;
      end else if (db_cnt == '0) begin
        sw2_db <= sw2_s2;
        db_cnt <= DB_LD;
      end else begin
        db_cnt <= db_cnt - ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      mode               <= 2'd0;
      timer              <= '0;
      ch3                <= 1'b0;
      ch4                <= 1'b0;
      ch6                <= 1'b0;
      ch7                <= 1'b0;
      ch8                <= 1'b1;
      busy               <= 1'b0;
      {rLed, gLed, bLed} <= 3'b011;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            state <= ARM;
            ch8   <= 1'b0;
            busy  <= 1'b1;
            timer <= GAP_LD;
          end
        end
        ARM: begin
          if (timer == '0) begin
            state      <= BURST;
            timer      <= burst_len - ONE;
            {ch3, ch4} <= pattern(mode, {CW{1'b0}});
          end else begin
            timer <= timer - ONE;
          end
        end
        BURST: begin
          if (timer == '0) begin
            state      <= POST;
            timer      <= GAP_LD;
            {ch3, ch4} <= 2'b00;
          end else begin
            timer      <= timer - ONE;
            // next burst index is burst_len - timer
            {ch3, ch4} <= pattern(mode, burst_len - timer);
          end
        end
        POST: begin
          if (timer == '0) begin
            state <= DONE;
            ch8   <= 1'b1;
          end else begin
            timer <= timer - ONE;
          end
        end
        DONE: begin
          state              <= IDLE;
          busy               <= 1'b0;
          mode               <= mode_inc;
          {ch7, ch6}         <= mode_inc;
          {rLed, gLed, bLed} <= led_code(mode_inc);
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ch8   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench for trigger_sequencer: presses queue expected frames,
// the frame checker pops them when ch8 opens a frame and compares cycle by cycle.
module tb_trigger_sequencer;

  localparam int DB = 16;
  localparam int P  = 4;
  localparam int G  = 8;

  logic clk = 1'b0;
  logic rst, sw2;
  logic ch3, ch4, ch6, ch7, ch8, busy, rLed, gLed, bLed;

  int n_chk   = 0;
  int n_err   = 0;
  int tb_mode = 0;
  int sb_q[$];

  trigger_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .PULSE_CYCLES   (P),
    .GAP_CYCLES     (G)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sw2 (sw2),
    .ch3 (ch3),
    .ch4 (ch4),
    .ch6 (ch6),
    .ch7 (ch7),
    .ch8 (ch8),
    .busy(busy),
    .rLed(rLed),
    .gLed(gLed),
    .bLed(bLed)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int led_exp(input int m);
    case (m)
      0:       return 3'b011;
      1:       return 3'b101;
      2:       return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  // expected {ch3,ch4} at frame cycle i (i=0 is the first cycle with ch8 low)
  function automatic int exp_ch34(input int m, input int i);
    int len, k, seg;
    bit c3, c4;
    len = (m == 2) ? 5 * P : 2 * P;
    if (i < G || i >= G + len) return 0;
    k   = i - G;
    seg = k / P;
    case (m)
      0:       begin c3 = (seg == 0); c4 = (seg == 1); end
      1:       begin c3 = 1'b1;       c4 = (seg == 1); end
      2:       begin c3 = (seg == 0 || seg == 2 || seg == 3); c4 = 1'b0; end
      default: begin c3 = (k % 2 == 1); c4 = 1'b1; end
    endcase
    return (c3 ? 2 : 0) + (c4 ? 1 : 0);
  endfunction

  task automatic press(input int hold);
    sb_q.push_back(tb_mode);
    tb_mode = (tb_mode + 1) % 4;
    sw2 = 1'b1;
    repeat (hold) tick();
    sw2 = 1'b0;
  endtask

  // press, release, then re-press while the frame is still running
  task automatic double_press();
    sb_q.push_back(tb_mode);
    tb_mode = (tb_mode + 1) % 4;
    sw2 = 1'b1;
    repeat (16) tick();
    sw2 = 1'b0;
    repeat (16) tick();
    sw2 = 1'b1;
    repeat (20) tick();
    sw2 = 1'b0;
  endtask

  // e = index of the first edge after which ch8 is low (edge 0 first samples sw2)
  task automatic wait_fall(output int e);
    e = 0;
    tick();
    while (ch8 && e < 200) begin
      e++;
      tick();
    end
  endtask

  task automatic idle_watch(input int n, input string tag);
    int cnt;
    cnt = 0;
    repeat (n) begin
      tick();
      if (!ch8 || busy) cnt++;
    end
    chk(tag, cnt, 0);
  endtask

  task automatic check_frame();
    int e, em, i, len, bad_pat, bad_mode;
    wait_fall(e);
    chk("latency", e, DB + 3);
    chk("sb_nonempty", int'(sb_q.size() > 0), 1);
    if (sb_q.size() == 0) return;
    em       = sb_q.pop_front();
    len      = (em == 2) ? 5 * P : 2 * P;
    i        = 0;
    bad_pat  = 0;
    bad_mode = 0;
    while (!ch8 && i < 100) begin
      if (int'({ch3, ch4}) != exp_ch34(em, i)) bad_pat++;
      if (int'({ch7, ch6}) != em || !busy) bad_mode++;
      i++;
      tick();
    end
    chk($sformatf("pattern_m%0d", em), bad_pat, 0);
    chk($sformatf("frame_len_m%0d", em), i, 2 * G + len);
    chk("mode_stable", bad_mode, 0);
    chk("done_busy", int'(busy), 1);
    chk("done_ch34", int'({ch3, ch4}), 0);
    tick();
    chk("idle_busy", int'(busy), 0);
    chk("mode_next", int'({ch7, ch6}), (em + 1) % 4);
    chk("leds_next", int'({rLed, gLed, bLed}), led_exp((em + 1) % 4));
  endtask

  initial begin
    int e, em;
    rst = 1'b1;
    sw2 = 1'b0;
    repeat (3) tick();
    chk("rst_ch8", int'(ch8), 1);
    chk("rst_ch34", int'({ch3, ch4}), 0);
    chk("rst_mode", int'({ch7, ch6}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_leds", int'({rLed, gLed, bLed}), 3'b011);
    rst = 1'b0;
    repeat (5) tick();

    sw2 = 1'b1;
    repeat (10) tick();
    sw2 = 1'b0;
    idle_watch(100, "glitch_no_frame");

    for (int m = 0; m < 4; m++) begin
      if (m == 2) begin
        fork
          double_press();
          check_frame();
        join
        idle_watch(100, "no_retrigger");
      end else begin
        fork
          press(30);
          check_frame();
        join
        repeat (30) tick();
      end
    end

    fork
      press(30);
      check_frame();
    join
    repeat (30) tick();

    // abort a mode1 frame with a mid-cycle reset during the burst
    sb_q.push_back(tb_mode);
    sw2 = 1'b1;
    wait_fall(e);
    chk("abort_latency", e, DB + 3);
    em = sb_q.pop_front();
    repeat (9) tick();
    chk("abort_pre_ch34", int'({ch3, ch4}), exp_ch34(em, 9));
    #3;
    rst = 1'b1;
    #1;
    chk("abort_ch34", int'({ch3, ch4}), 0);
    chk("abort_ch8", int'(ch8), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_mode", int'({ch7, ch6}), 0);
    chk("abort_leds", int'({rLed, gLed, bLed}), 3'b011);
    sw2     = 1'b0;
    tb_mode = 0;
    repeat (2) tick();
    rst = 1'b0;
    idle_watch(60, "post_abort_idle");
    chk("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
